// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, field positions and the loader FSM states.
package cpu_pkg;

    localparam int INSTR_W = 24;

    localparam int OPC_HI = 23;
    localparam int OPC_LO = 20;
    localparam int WA_HI  = 19;
    localparam int WA_LO  = 16;
    localparam int RA1_HI = 15;
    localparam int RA1_LO = 12;
    localparam int RA2_HI = 11;
    localparam int RA2_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Big-endian byte insertion: byte 0 carries opcode/WA, byte 1 RA1/RA2, byte 2 the immediate.
    function automatic logic [INSTR_W-1:0] insert_byte(
        input logic [INSTR_W-1:0] word,
        input logic [1:0]         idx,
        input logic [7:0]         data
    );
        logic [INSTR_W-1:0] res;
        res = word;
        case (idx)
            2'd0:    res[OPC_HI:WA_LO]  = data;
            2'd1:    res[RA1_HI:RA2_LO] = data;
            2'd2:    res[IMM_HI:IMM_LO] = data;
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 8-bit program bytes into 24-bit instruction words and writes them
// into instruction memory while holding the CPU in reset.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               load_start,
    input  logic [ADDR_W-1:0]  prog_len,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done
);

    state_t              state_r;
    logic [1:0]          idx_r;
    logic [ADDR_W-1:0]   len_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [INSTR_W-1:0]  wdata_r;
    logic                byte_ready_r;
    logic                we_r;
    logic                busy_r;
    logic                done_r;
    logic                accept_s;
    logic                last_s;

    assign accept_s = byte_valid && byte_ready_r;
    assign last_s   = (addr_r == (len_r - {{(ADDR_W-1){1'b0}}, 1'b1}));

    // Loader FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            idx_r        <= 2'd0;
            len_r        <= '0;
            addr_r       <= '0;
            wdata_r      <= '0;
            byte_ready_r <= 1'b0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_start) begin
                        len_r  <= prog_len;
                        addr_r <= '0;
                        idx_r  <= 2'd0;
                        busy_r <= 1'b1;
                        if (prog_len != '0) begin
                            state_r      <= RECV;
                            byte_ready_r <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        wdata_r <= insert_byte(wdata_r, idx_r, byte_data);
                        if (idx_r == 2'd2) begin
                            state_r      <= WRITE;
                            idx_r        <= 2'd0;
                            byte_ready_r <= 1'b0;
                            we_r         <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 2'd1;
                        end
                    end else begin
                        state_r <= RECV;
                    end
                end
                WRITE: begin
                    we_r <= 1'b0;
                    if (last_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r      <= RECV;
                        addr_r       <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        idx_r        <= 2'd0;
                        byte_ready_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    idx_r        <= 2'd0;
                    byte_ready_r <= 1'b0;
                    we_r         <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign busy       = busy_r;
    assign cpu_hold   = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle-accurate vector table plus hand sequences.
module tb_imem_loader;
    import cpu_pkg::*;

    logic        CLK;
    logic        reset;
    logic        load_start;
    logic [7:0]  prog_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [23:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] wq[$];

    imem_loader #(.ADDR_W(8)) dut (
        .CLK(CLK), .reset(reset), .load_start(load_start), .prog_len(prog_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (reset && imem_we) wq.push_back({imem_addr, imem_wdata});
        if (reset && done) done_cnt = done_cnt + 1;
    end

    typedef struct {
        logic        ls;
        logic [7:0]  len;
        logic        bv;
        logic [7:0]  d;
        logic        br;
        logic        we;
        logic [7:0]  addr;
        logic [23:0] wd;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {29'd0, byte_ready, imem_we, imem_addr, imem_wdata, busy, done, cpu_hold};
    endfunction

    function automatic logic [63:0] mk(input logic br, input logic we, input logic [7:0] a,
                                       input logic [23:0] wd, input logic bsy, input logic dn);
        return {29'd0, br, we, a, wd, bsy, dn, bsy};
    endfunction

    // Called at a negedge; pulses load_start for one cycle.
    task automatic start(input logic [7:0] len);
        load_start = 1'b1;
        prog_len   = len;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    // Called at a negedge; waits for byte_ready then presents one byte for one edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) chk("byte_ready_timeout", 64'd0, 64'd1);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge CLK);
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) chk("idle_timeout", 64'd0, 64'd1);
        @(negedge CLK);
    endtask

    task automatic clear_log();
        wq.delete();
        done_cnt = 0;
    endtask

    logic [7:0] stream[6];

    initial begin
        stream[0] = 8'h11; stream[1] = 8'h23; stream[2] = 8'h05;
        stream[3] = 8'h20; stream[4] = 8'h00; stream[5] = 8'h03;

        //                 ls    len   bv    d      br    we    addr   wdata        busy  done
        vt[0]  = '{1'b1, 8'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 24'h000000, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 8'd0, 1'b1, 8'h11, 1'b1, 1'b0, 8'd0, 24'h110000, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 8'd0, 1'b1, 8'h23, 1'b1, 1'b0, 8'd0, 24'h112300, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 8'd0, 1'b1, 8'h05, 1'b0, 1'b1, 8'd0, 24'h112305, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1, 24'h112305, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 8'd0, 1'b1, 8'h20, 1'b1, 1'b0, 8'd1, 24'h202305, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 8'd0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd1, 24'h200005, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 8'd0, 1'b1, 8'h03, 1'b0, 1'b1, 8'd1, 24'h200003, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 24'h200003, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 24'h200003, 1'b0, 1'b0};
        vt[10] = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 24'h200003, 1'b0, 1'b0};

        reset = 1'b0; load_start = 1'b0; prog_len = 8'd0; byte_valid = 1'b0; byte_data = 8'd0;
        repeat (3) @(negedge CLK);
        chk("reset_state", outs(), 64'd0);
        reset = 1'b1;
        @(negedge CLK);
        clear_log();

        // Basic prog_len=2 load, cycle by cycle.
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            load_start = vt[i].ls; prog_len = vt[i].len;
            byte_valid = vt[i].bv; byte_data = vt[i].d;
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d", i), outs(),
                mk(vt[i].br, vt[i].we, vt[i].addr, vt[i].wd, vt[i].bsy, vt[i].dn));
        end
        @(negedge CLK);
        load_start = 1'b0; byte_valid = 1'b0;
        chk("table_done_count", 64'(done_cnt), 64'd1);
        clear_log();

        // Same stream with 2-cycle gaps between bytes.
        start(8'd2);
        for (int i = 0; i < 6; i++) begin
            send_byte(stream[i]);
            for (int g = 0; g < 2; g++) begin
                if ((i % 3) != 2) chk($sformatf("gap_ready_b%0d_g%0d", i, g), 64'(byte_ready), 64'd1);
                @(negedge CLK);
            end
        end
        wait_idle();
        chk("gap_write_count", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("gap_write0", 64'(wq[0]), 64'h00112305);
            chk("gap_write1", 64'(wq[1]), 64'h01200003);
        end
        chk("gap_done_count", 64'(done_cnt), 64'd1);
        clear_log();

        // prog_len=0: straight to DONE, one cycle of hold, no writes.
        start(8'd0);
        chk("len0_done_cycle", {61'd0, done, cpu_hold, imem_we}, {61'd0, 3'b110});
        @(negedge CLK);
        chk("len0_after", {61'd0, done, cpu_hold, busy}, 64'd0);
        repeat (2) @(negedge CLK);
        chk("len0_no_writes", 64'(wq.size()), 64'd0);
        clear_log();

        // Reset after 4 bytes of a prog_len=3 load.
        start(8'd3);
        for (int i = 0; i < 4; i++) send_byte(stream[i]);
        reset = 1'b0;
        #1;
        chk("abort_outputs", outs(), 64'd0);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        clear_log();
        start(8'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_idle();
        chk("abort_reload_count", 64'(wq.size()), 64'd1);
        if (wq.size() == 1) chk("abort_reload_write", 64'(wq[0]), 64'h00AABBCC);
        clear_log();

        // load_start pulsed mid-RECV with a different prog_len must be ignored.
        start(8'd2);
        send_byte(stream[0]);
        start(8'd1);
        for (int i = 1; i < 6; i++) send_byte(stream[i]);
        wait_idle();
        chk("midload_write_count", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("midload_write0", 64'(wq[0]), 64'h00112305);
            chk("midload_write1", 64'(wq[1]), 64'h01200003);
        end
        chk("midload_done_count", 64'(done_cnt), 64'd1);
        clear_log();

        // Two back-to-back single-instruction loads.
        for (int n = 0; n < 2; n++) begin
            start(8'd1);
            send_byte(8'h3C); send_byte(8'h4D); send_byte(8'h5E);
            wait_idle();
        end
        chk("b2b_write_count", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("b2b_write0", 64'(wq[0]), 64'h003C4D5E);
            chk("b2b_write1", 64'(wq[1]), 64'h003C4D5E);
        end
        chk("b2b_done_count", 64'(done_cnt), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction memory address width, so depth is 2^ADDR_W words.
REQ-002 SHALL have port CLK, input, 1: single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port load_start, input, 1: request to begin a program load, sampled only in IDLE.
REQ-005 SHALL have port prog_len, input, ADDR_W: number of 24-bit instructions to load, latched on the accepted load_start.
REQ-006 SHALL have port byte_valid, input, 1: byte_data is valid.
REQ-007 SHALL have port byte_data, input, 8: incoming program byte.
REQ-008 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we, output, 1: instruction memory write strobe.
REQ-010 SHALL have port imem_addr, output, ADDR_W: instruction memory write address.
REQ-011 SHALL have port imem_wdata, output, 24: assembled instruction word.
REQ-012 SHALL have port cpu_hold, output, 1: holds the CPU in reset while a load is in progress.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse marking load completion.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE and DONE.
REQ-016 SHALL move IDLE->RECV on load_start=1 with prog_len!=0, clearing the byte index and imem_addr to 0.
REQ-017 SHALL move IDLE->DONE on load_start=1 with prog_len==0, issuing no writes.
REQ-018 SHALL ignore load_start in all states other than IDLE.
REQ-019 SHALL drive byte_ready=1 only in RECV; a byte is accepted only when byte_valid && byte_ready.
REQ-020 SHALL pack accepted bytes big-endian: byte 0 -> [23:16] (opcode, WA), byte 1 -> [15:8] (RA1, RA2), byte 2 -> [7:0] (immediate).
REQ-021 SHALL hold state and the byte index unchanged while byte_valid=0 in RECV; gaps between bytes are allowed.
REQ-022 SHALL move RECV->WRITE on the cycle the third byte is accepted.
REQ-023 SHALL hold imem_we=1 for exactly one cycle, in WRITE, with imem_addr and imem_wdata stable for that cycle.
REQ-024 SHALL move WRITE->DONE if imem_addr==prog_len-1; otherwise it SHALL increment imem_addr and return to RECV with the byte index reset to 0.
REQ-025 SHALL hold done=1 for one cycle in DONE and then return to IDLE.
REQ-026 SHALL drive cpu_hold=busy.
REQ-027 SHALL give imem_we, imem_wdata and imem_addr a latency of 1 cycle from the acceptance of byte 2.
REQ-028 SHALL limit the final write address to prog_len-1 with no wrap; a prog_len of 2^ADDR_W-1 gives a last address of 2^ADDR_W-2.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state IDLE and set byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy and done to 0.
REQ-030 SHALL abort a load cleanly if reset is asserted mid-load; the partial word is discarded and the next load restarts at address 0.

Structure
REQ-031 SHALL take INSTR_W=24, the field bit positions (opcode 23:20, WA 19:16, RA1 15:12, RA2 11:8, imm 7:0) and the FSM state enum from the shared package cpu_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 SHALL test: prog_len=2, bytes 11,23,05,20,00,03 (hex) -> writes 0x112305 @0 and 0x200003 @1, then a single done pulse.
REQ-034 SHALL test: the same stream with 2-cycle byte_valid gaps -> identical writes, byte_ready held at 1 throughout RECV.
REQ-035 SHALL test: prog_len=0 -> no imem_we, done=1 on the cycle after load_start, cpu_hold high for that one cycle only.
REQ-036 SHALL test: reset pulled low after 4 bytes of a prog_len=3 load -> all outputs 0 immediately; a fresh load then writes from addr 0.
REQ-037 SHALL test: load_start pulsed during RECV -> no effect, and prog_len remains the originally latched value.
REQ-038 SHALL test: two back-to-back loads (prog_len=1) -> the second write lands at addr 0, and there are two done pulses.
